// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared defaults and ratio sanitising for the clock-enable generator
package clk_en_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int INIT_DIV_DEF = 4;

    // A divide ratio of 0 has no meaning, so it runs as divide-by-1
    function automatic logic [31:0] ratio_fix(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/clk_enable_channel.sv
// clk_enable_channel: one divide-by-N channel with shadowed ratio, enable pulse and square wave
module clk_enable_channel
    import clk_en_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int INIT_DIV = INIT_DIV_DEF
) (
    input  logic             board_clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_val,
    input  logic             run,
    input  logic             sync,
    output logic             ce,
    output logic             sq,
    output logic             pend
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] INIT = CNT_W'(INIT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
    logic             pend_q, pend_d, ce_q, ce_d, sq_q, sq_d, run_q, run_d;
    logic             term, load;

    // Next state: the shadow equals the active ratio whenever nothing is pending,
    // so every load point (terminal count, stop, sync) simply copies the shadow.
    // A stopped channel spends its first running cycle at cnt=0 so a full period
    // elapses before the first pulse.
    always_comb begin
        term   = cnt_q == act_q - ONE;
        load   = !run || sync || term;
        shd_d  = wr_en ? CNT_W'(ratio_fix(32'(wr_val))) : shd_q;
        pend_d = !load && (wr_en || pend_q);
        act_d  = load ? shd_d : act_q;
        cnt_d  = (load || !run_q) ? '0 : cnt_q + ONE;
        run_d  = run;
        ce_d   = run && !sync && (cnt_d == act_d - ONE);
        sq_d   = run && !sync && (cnt_d >= (act_d >> 1));
    end

    // State and registered outputs, asynchronously cleared to the reset ratio
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            act_q  <= INIT;
            shd_q  <= INIT;
            pend_q <= 1'b0;
            ce_q   <= 1'b0;
            sq_q   <= 1'b0;
            run_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            ce_q   <= ce_d;
            sq_q   <= sq_d;
            run_q  <= run_d;
        end
    end

    assign ce   = ce_q;
    assign sq   = sq_q;
    assign pend = pend_q;

endmodule

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: NUM_CH programmable clock-enable channels sharing one write port
module clk_enable_gen
    import clk_en_pkg::*;
#(
    parameter int   NUM_CH   = 4,
    parameter int   CNT_W    = CNT_W_DEF,
    parameter int   INIT_DIV = INIT_DIV_DEF,
    localparam int  CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              board_clk,
    input  logic              reset,
    input  logic              div_wr_en,
    input  logic [CH_W-1:0]   div_wr_ch,
    input  logic [CNT_W-1:0]  div_wr_val,
    input  logic [NUM_CH-1:0] ch_run,
    input  logic              sync_all,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] div_pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_enable_channel #(
            .CNT_W    (CNT_W),
            .INIT_DIV (INIT_DIV)
        ) u_ch (
            .board_clk (board_clk),
            .reset     (reset),
            .wr_en     (div_wr_en && (32'(div_wr_ch) == i)),
            .wr_val    (div_wr_val),
            .run       (ch_run[i]),
            .sync      (sync_all),
            .ce        (ce[i]),
            .sq        (sq[i]),
            .pend      (div_pend[i])
        );
    end

endmodule
